text_buffer_ctrl: RTL and testbench
===================================

# text_buffer_ctrl

Write-side controller for the 12×9 on-screen character buffer. It turns PS/2 scan-code bytes into buffer writes through the scan-code→ASCII lookup RAM, and keeps the text cursor. It also arbitrates the buffer's single write port between the keyboard path and processor writes, and runs a full-screen clear sweep. It sits between the PS/2 interface, the ASCII lookup RAM, the processor wrapper and the character buffer read by the VGA sprite path.

## Interface
Parameters:
- BUF_W, 12, characters per row
- BUF_H, 9, rows
- ADDR_W, 7, buffer address width; must satisfy 2^ADDR_W ≥ BUF_W·BUF_H

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low
- kb_valid  in  1  one-cycle strobe; kb_data valid and error-free
- kb_data  in  8  PS/2 scan-code byte
- lut_addr  out  8  ASCII lookup RAM address (registered scan code)
- lut_data  in  8  ASCII lookup RAM output; synchronous, 1-cycle latency
- proc_req  in  1  processor write request; level, held until granted
- proc_addr  in  ADDR_W  processor write address
- proc_wdata  in  8  processor write data
- proc_gnt  out  1  processor write accepted this cycle
- clr  in  1  one-cycle strobe; start clear sweep
- buf_we  out  1  buffer write enable
- buf_waddr  out  ADDR_W  buffer write address
- buf_wdata  out  8  buffer write data
- cursor  out  ADDR_W  next keyboard write position
- busy  out  1  high in any state other than IDLE and BREAK
- overrun  out  1  sticky: a keyboard byte was dropped; cleared by clr

## Operation
- DEPTH = BUF_W·BUF_H = 108. All cursor arithmetic is modulo DEPTH.
- Keyboard FSM states: IDLE, BREAK, LOOKUP, COMMIT, CLEAR.
- IDLE, kb_valid:
  - 0xF0 → BREAK.
  - 0xE0 → stay in IDLE; byte ignored.
  - Any other byte → lut_addr ← kb_data, go to LOOKUP.
- BREAK, kb_valid: byte discarded → IDLE.
- LOOKUP: unconditional → COMMIT.
- COMMIT: decode lut_data.
  - 0x00: no write → IDLE.
  - 0x08 (backspace): cursor ← max(cursor−1, 0); write 0x20 at the new cursor.
  - 0x0D (enter): cursor ← (cursor/BUF_W + 1)·BUF_W, or 0 if that is ≥ DEPTH; no write.
  - 0x20–0x7E: write the character at cursor; cursor ← cursor+1, wrapping DEPTH−1 → 0.
  - Other codes: dropped.
  - Leave COMMIT → IDLE only once the write (if any) has been performed.
- Arbitration: the processor has fixed priority. While proc_req is high in COMMIT, the keyboard write stalls in COMMIT with its character held. lut_data is captured on COMMIT entry so a stall cannot corrupt it.
- kb_valid in LOOKUP, COMMIT or CLEAR: byte dropped, overrun ← 1.
- clr in any state → CLEAR. CLEAR writes 0x20 to addresses 0…DEPTH−1, one per cycle, then → IDLE with cursor = 0. An in-flight keyboard character is discarded. overrun ← 0 on clr.
- proc_gnt = proc_req && state ≠ CLEAR.

## Timing
- Reset values: state IDLE, cursor 0, lut_addr 0x00, overrun 0, sweep counter 0, busy 0. buf_we and proc_gnt are 0 during reset.
- buf_we, buf_waddr, buf_wdata and proc_gnt are combinational from registered state and proc_req. A granted processor write lands on the same clock edge.
- Keyboard latency: kb_valid at edge t (IDLE) → LOOKUP at t+1, lut_data valid → COMMIT at t+2. buf_we is high during cycle t+2 when not stalled. The cursor updates at the end of the write cycle.
- Enter and 0x00 spend one cycle in COMMIT with buf_we low.
- A clear sweep takes exactly DEPTH cycles of buf_we high. The first write (addr 0) occurs in the cycle after clr.
- clr during CLEAR restarts the sweep at address 0.
- clr and kb_valid in the same cycle: clr wins; the byte is dropped and overrun stays 0.
- Async reset mid-sweep or mid-COMMIT: immediate return to reset values; no partial write completes after reset asserts.

## Structure
- Package text_buf_pkg holds:
  - FSM state encoding.
  - Constants SC_BREAK = 0xF0, SC_EXT = 0xE0, ASC_BS = 0x08, ASC_CR = 0x0D, ASC_SPACE = 0x20, ASC_MAX = 0x7E.
  - DEPTH derived from BUF_W/BUF_H.
- Sub-module text_cursor: holds the cursor register and performs increment-wrap, saturating decrement and next-row operations, selected by a 2-bit op input. This keeps the divide-by-BUF_W logic isolated.
- The FSM, write-port mux and sweep counter stay in text_buffer_ctrl.

## Test plan
- Reset → make 0x1C, lut_data = 0x61: buf_we at t+2, addr 0, data 0x61; cursor = 1.
- Cursor = 107, printable key → write at 107, cursor = 0. Then 0x0D at cursor 30 → cursor 36; at cursor 100 → cursor 0.
- Cursor = 0, backspace → write 0x20 at 0, cursor stays 0. Cursor = 5, backspace → write 0x20 at 4, cursor = 4.
- Sequence 0xF0, 0x1C → no buf_we, cursor unchanged. Second kb_valid during LOOKUP → overrun = 1, first character still written.
- proc_req held through keyboard COMMIT:
  - Processor write lands first.
  - Keyboard write lands the cycle after proc_req drops, with the original character.
- clr mid-COMMIT → 108 consecutive 0x20 writes at addresses 0..107, proc_gnt low throughout, then cursor 0, overrun 0. Async reset at sweep address 50 → buf_we drops immediately.

Source files
------------

// File: rtl/text_buffer_ctrl_pkg.sv
// text_buf_pkg: shared definitions for the character-buffer write controller.
//   - default geometry of the 12x9 text buffer and its depth
//   - PS/2 scan-code and ASCII control constants
//   - keyboard FSM state and cursor-operation encodings
package text_buf_pkg;

    localparam int unsigned DEF_BUF_W  = 12;
    localparam int unsigned DEF_BUF_H  = 9;
    localparam int unsigned DEF_ADDR_W = 7;

    function automatic int unsigned buf_depth(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    localparam int unsigned DEPTH = buf_depth(DEF_BUF_W, DEF_BUF_H);

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_MAX   = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_LOOKUP,
        ST_COMMIT,
        ST_CLEAR
    } kb_state_e;

    typedef enum logic [1:0] {
        CUR_HOLD,
        CUR_INC,
        CUR_DEC,
        CUR_ROW
    } cur_op_e;

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// text_buffer_ctrl_if: keyboard, lookup-RAM, processor and buffer-write signals
// of the text buffer controller.
//   master : the controller (drives lut_addr, proc_gnt, buf_*)
//   slave  : the surrounding system (PS/2, lookup RAM, processor, buffer)
interface text_buffer_ctrl_if #(
    parameter int unsigned ADDR_W = 7
) ();
    logic              kb_valid;
    logic [7:0]        kb_data;
    logic [7:0]        lut_addr;
    logic [7:0]        lut_data;
    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic [7:0]        proc_wdata;
    logic              proc_gnt;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [7:0]        buf_wdata;

    modport master (
        input  kb_valid, kb_data, lut_data, proc_req, proc_addr, proc_wdata,
        output lut_addr, proc_gnt, buf_we, buf_waddr, buf_wdata
    );

    modport slave (
        output kb_valid, kb_data, lut_data, proc_req, proc_addr, proc_wdata,
        input  lut_addr, proc_gnt, buf_we, buf_waddr, buf_wdata
    );
endinterface

// File: rtl/text_buffer_ctrl_cursor.sv
// text_cursor: text cursor register for the character buffer.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset (cursor -> 0)
//   clear_i  : force cursor to 0 (clear sweep start), overrides op_i
//   op_i     : HOLD / INC (wrap DEPTH-1 -> 0) / DEC (saturate at 0) / ROW (next row start, wrap to 0)
//   cursor_o : current cursor position
//   prev_o   : saturating predecessor of the cursor (backspace target)
module text_cursor
    import text_buf_pkg::*;
#(
    parameter int unsigned BUF_W  = DEF_BUF_W,
    parameter int unsigned BUF_H  = DEF_BUF_H,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  cur_op_e           op_i,
    output logic [ADDR_W-1:0] cursor_o,
    output logic [ADDR_W-1:0] prev_o
);

    localparam int unsigned DEPTH_L = buf_depth(BUF_W, BUF_H);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_L - 1);

    logic [ADDR_W-1:0] cursor_q, cursor_d;
    int unsigned       row_u;

    always_comb begin
        // Start of the following row; the divide is by a constant.
        row_u  = (32'(cursor_q) / BUF_W + 1) * BUF_W;
        prev_o = (cursor_q == '0) ? '0 : cursor_q - ADDR_W'(1);

        cursor_d = cursor_q;
        if (clear_i) begin
            cursor_d = '0;
        end else begin
            unique case (op_i)
                CUR_INC: cursor_d = (cursor_q == LAST) ? '0 : cursor_q + ADDR_W'(1);
                CUR_DEC: cursor_d = prev_o;
                CUR_ROW: cursor_d = (row_u >= DEPTH_L) ? '0 : ADDR_W'(row_u);
                default: cursor_d = cursor_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cursor_q <= '0;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    assign cursor_o = cursor_q;

endmodule

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: write-side controller for the 12x9 on-screen character buffer.
// Turns PS/2 scan codes into buffer writes via the scan-code->ASCII lookup RAM,
// keeps the text cursor, arbitrates the single buffer write port (processor has
// fixed priority) and runs the full-screen clear sweep.
//   clk      : system clock
//   reset    : asynchronous, active-low
//   bus      : kb_valid/kb_data in, lut_addr out / lut_data in, proc_req/addr/wdata in,
//              proc_gnt out, buf_we/buf_waddr/buf_wdata out
//   clr      : one-cycle strobe, start clear sweep
//   cursor   : next keyboard write position
//   busy     : FSM not in IDLE or BREAK
//   overrun  : sticky, a keyboard byte was dropped; cleared by clr
module text_buffer_ctrl
    import text_buf_pkg::*;
#(
    parameter int unsigned BUF_W  = DEF_BUF_W,
    parameter int unsigned BUF_H  = DEF_BUF_H,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    text_buffer_ctrl_if.master   bus,
    input  logic                 clr,
    output logic [ADDR_W-1:0]    cursor,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned BUF_DEPTH = buf_depth(BUF_W, BUF_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

    kb_state_e         state_q, state_d;
    logic [7:0]        lut_addr_q, lut_addr_d;
    logic [7:0]        char_q;
    logic              first_q;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    logic [7:0]        char_cur;
    logic              is_print, is_bs, is_cr;
    logic              kb_wr, kb_stall;
    cur_op_e           cur_op;
    logic [ADDR_W-1:0] cur_prev;

    text_cursor #(
        .BUF_W (BUF_W),
        .BUF_H (BUF_H),
        .ADDR_W(ADDR_W)
    ) u_cursor (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (clr),
        .op_i    (cur_op),
        .cursor_o(cursor),
        .prev_o  (cur_prev)
    );

    // The RAM output is only guaranteed on the first COMMIT cycle; afterwards
    // the held copy is used so a processor stall cannot change the character.
    always_comb begin
        char_cur = first_q ? bus.lut_data : char_q;
        is_print = (char_cur >= ASC_SPACE) && (char_cur <= ASC_MAX);
        is_bs    = (char_cur == ASC_BS);
        is_cr    = (char_cur == ASC_CR);
        kb_wr    = (state_q == ST_COMMIT) && (is_print || is_bs);
        kb_stall = kb_wr && bus.proc_req;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_CLEAR;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.kb_valid) begin
                        if (bus.kb_data == SC_BREAK) begin
                            state_d = ST_BREAK;
                        end else if (bus.kb_data != SC_EXT) begin
                            state_d = ST_LOOKUP;
                        end
                    end
                end
                ST_BREAK:  if (bus.kb_valid) state_d = ST_IDLE;
                ST_LOOKUP: state_d = ST_COMMIT;
                ST_COMMIT: if (!kb_stall) state_d = ST_IDLE;
                ST_CLEAR:  if (sweep_q == LAST_ADDR) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs (write-port mux, cursor operation, status)
    always_comb begin
        bus.buf_we    = 1'b0;
        bus.buf_waddr = '0;
        bus.buf_wdata = '0;
        bus.proc_gnt  = 1'b0;
        cur_op        = CUR_HOLD;

        // Gated by reset so nothing reaches the buffer while reset is held.
        if (reset) begin
            if (state_q == ST_CLEAR) begin
                bus.buf_we    = 1'b1;
                bus.buf_waddr = sweep_q;
                bus.buf_wdata = ASC_SPACE;
            end else if (bus.proc_req) begin
                bus.buf_we    = 1'b1;
                bus.buf_waddr = bus.proc_addr;
                bus.buf_wdata = bus.proc_wdata;
                bus.proc_gnt  = 1'b1;
            end else if (kb_wr) begin
                bus.buf_we    = 1'b1;
                bus.buf_waddr = is_bs ? cur_prev : cursor;
                bus.buf_wdata = is_bs ? ASC_SPACE : char_cur;
            end
        end

        if ((state_q == ST_COMMIT) && !kb_stall) begin
            if (is_print)   cur_op = CUR_INC;
            else if (is_bs) cur_op = CUR_DEC;
            else if (is_cr) cur_op = CUR_ROW;
        end

        busy = (state_q != ST_IDLE) && (state_q != ST_BREAK);
    end

    // Datapath next values
    always_comb begin
        lut_addr_d = lut_addr_q;
        if (!clr && (state_q == ST_IDLE) && bus.kb_valid &&
            (bus.kb_data != SC_BREAK) && (bus.kb_data != SC_EXT)) begin
            lut_addr_d = bus.kb_data;
        end

        overrun_d = overrun_q;
        if (clr) begin
            overrun_d = 1'b0;
        end else if (bus.kb_valid && ((state_q == ST_LOOKUP) ||
                     (state_q == ST_COMMIT) || (state_q == ST_CLEAR))) begin
            overrun_d = 1'b1;
        end

        sweep_d = sweep_q;
        if (clr) begin
            sweep_d = '0;
        end else if (state_q == ST_CLEAR) begin
            sweep_d = (sweep_q == LAST_ADDR) ? '0 : sweep_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lut_addr_q <= '0;
            char_q     <= '0;
            first_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sweep_q    <= '0;
        end else begin
            lut_addr_q <= lut_addr_d;
            overrun_q  <= overrun_d;
            sweep_q    <= sweep_d;
            first_q    <= (state_q == ST_LOOKUP) && !clr;
            if (state_q == ST_COMMIT) begin
                char_q <= char_cur;
            end
        end
    end

    assign bus.lut_addr = lut_addr_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
module tb_text_buffer_ctrl;

    localparam logic [7:0] SC_KEY = 8'h1C;
    localparam logic [7:0] SC_ENT = 8'h5A;
    localparam logic [7:0] SC_SPC = 8'h29;

    logic       clk;
    logic       reset;
    logic       clr;
    logic [6:0] cursor;
    logic       busy;
    logic       overrun;

    text_buffer_ctrl_if #(.ADDR_W(7)) bus ();

    text_buffer_ctrl #(
        .BUF_W (12),
        .BUF_H (9),
        .ADDR_W(7)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .clr    (clr),
        .cursor (cursor),
        .busy   (busy),
        .overrun(overrun)
    );

    int checks;
    int failures;

    logic [7:0] lut_mem [256];
    logic [7:0] vram    [108];
    logic [7:0] scr     [108];
    int         mcur;

    typedef struct {
        int         start;
        logic [7:0] lutv;
        bit         exp_we;
        int         exp_addr;
        logic [7:0] exp_data;
        int         exp_cur;
    } vec_t;

    vec_t vecs [12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous lookup RAM, one cycle latency.
    always @(posedge clk) bus.lut_data <= lut_mem[bus.lut_addr];

    // Character buffer seen by the VGA path.
    always @(posedge clk) begin
        if (bus.buf_we === 1'b1 && bus.buf_waddr < 7'd108) vram[bus.buf_waddr] <= bus.buf_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        #1;
        while (busy !== 1'b0 && n < maxc) begin
            cyc();
            #1;
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic send_key(input logic [7:0] code);
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = code;
        cyc();
        bus.kb_valid = 1'b0;
        wait_idle(20);
    endtask

    task automatic do_clear();
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        wait_idle(200);
    endtask

    task automatic goto_cursor(input int n);
        do_clear();
        for (int i = 0; i < n / 12; i++) send_key(SC_ENT);
        for (int i = 0; i < n % 12; i++) send_key(SC_SPC);
    endtask

    // Caller has just deasserted clr at a negedge.
    task automatic sweep_check();
        int bad;
        bad = 0;
        for (int i = 0; i < 108; i++) begin
            if (i > 0) cyc();
            #1;
            if (bus.buf_we !== 1'b1 || bus.buf_waddr !== 7'(i) ||
                bus.buf_wdata !== 8'h20 || bus.proc_gnt !== 1'b0) bad++;
        end
        chk("sweep_bad_cycles", bad, 0);
        cyc();
        #1;
        chk("sweep_end_busy", busy, 0);
        chk("sweep_end_cursor", cursor, 0);
        chk("sweep_end_overrun", overrun, 0);
    endtask

    task automatic proc_write(input int a, input logic [7:0] d);
        cyc();
        bus.proc_req   = 1'b1;
        bus.proc_addr  = 7'(a);
        bus.proc_wdata = d;
        #1;
        chk("proc_gnt", bus.proc_gnt, 1);
        cyc();
        bus.proc_req = 1'b0;
    endtask

    // Reference behaviour of one accepted key.
    task automatic model_key(input logic [7:0] code);
        logic [7:0] c;
        int         r;
        c = lut_mem[code];
        if (c == 8'h08) begin
            mcur = (mcur > 0) ? mcur - 1 : 0;
            scr[mcur] = 8'h20;
        end else if (c == 8'h0D) begin
            r = (mcur / 12 + 1) * 12;
            mcur = (r >= 108) ? 0 : r;
        end else if (c >= 8'h20 && c <= 8'h7E) begin
            scr[mcur] = c;
            mcur = (mcur + 1) % 108;
        end
    endtask

    initial begin
        int         wes, n, bad, r, a, k;
        logic [7:0] code, d;

        checks   = 0;
        failures = 0;
        vecs[0]  = '{0,   8'h61, 1'b1, 0,   8'h61, 1};
        vecs[1]  = '{107, 8'h41, 1'b1, 107, 8'h41, 0};
        vecs[2]  = '{30,  8'h0D, 1'b0, 0,   8'h00, 36};
        vecs[3]  = '{100, 8'h0D, 1'b0, 0,   8'h00, 0};
        vecs[4]  = '{0,   8'h08, 1'b1, 0,   8'h20, 0};
        vecs[5]  = '{5,   8'h08, 1'b1, 4,   8'h20, 4};
        vecs[6]  = '{12,  8'h0D, 1'b0, 0,   8'h00, 24};
        vecs[7]  = '{7,   8'h00, 1'b0, 0,   8'h00, 7};
        vecs[8]  = '{9,   8'h7F, 1'b0, 0,   8'h00, 9};
        vecs[9]  = '{3,   8'h7E, 1'b1, 3,   8'h7E, 4};
        vecs[10] = '{96,  8'h0D, 1'b0, 0,   8'h00, 0};
        vecs[11] = '{11,  8'h20, 1'b1, 11,  8'h20, 12};

        for (int i = 0; i < 256; i++) lut_mem[i] = 8'h00;
        lut_mem[SC_ENT] = 8'h0D;
        lut_mem[SC_SPC] = 8'h20;

        reset          = 1'b0;
        clr            = 1'b0;
        bus.kb_valid   = 1'b0;
        bus.kb_data    = 8'h00;
        bus.proc_req   = 1'b1;
        bus.proc_addr  = 7'd3;
        bus.proc_wdata = 8'h55;

        // Reset state, with a processor request pending.
        #12;
        chk("rst_buf_we", bus.buf_we, 0);
        chk("rst_proc_gnt", bus.proc_gnt, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_lut_addr", bus.lut_addr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        bus.proc_req = 1'b0;
        cyc();
        reset = 1'b1;

        // clr and kb_valid together: clr wins, no overrun; full sweep timing.
        cyc();
        clr          = 1'b1;
        bus.kb_valid = 1'b1;
        bus.kb_data  = SC_KEY;
        cyc();
        clr          = 1'b0;
        bus.kb_valid = 1'b0;
        sweep_check();
        chk("clr_kb_lut_addr", bus.lut_addr, 0);

        // Table of single-key vectors with exact latency.
        for (int v = 0; v < 12; v++) begin
            goto_cursor(vecs[v].start);
            lut_mem[SC_KEY] = vecs[v].lutv;
            cyc();
            bus.kb_valid = 1'b1;
            bus.kb_data  = SC_KEY;
            cyc();
            bus.kb_valid = 1'b0;
            #1;
            chk("vec_lookup_we", bus.buf_we, 0);
            chk("vec_lookup_busy", busy, 1);
            cyc();
            #1;
            chk("vec_commit_we", bus.buf_we, 32'(vecs[v].exp_we));
            if (vecs[v].exp_we) begin
                chk("vec_commit_addr", bus.buf_waddr, vecs[v].exp_addr);
                chk("vec_commit_data", bus.buf_wdata, vecs[v].exp_data);
            end
            cyc();
            #1;
            chk("vec_cursor", cursor, vecs[v].exp_cur);
            chk("vec_busy_after", busy, 0);
        end

        // Processor holds the port through COMMIT; the key lands afterwards
        // with the character captured on COMMIT entry.
        goto_cursor(10);
        lut_mem[SC_KEY] = 8'h62;
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = SC_KEY;
        cyc();
        bus.kb_valid   = 1'b0;
        bus.proc_req   = 1'b1;
        bus.proc_addr  = 7'd50;
        bus.proc_wdata = 8'hAA;
        #1;
        chk("stall_lookup_gnt", bus.proc_gnt, 1);
        chk("stall_lookup_addr", bus.buf_waddr, 50);
        cyc();
        #1;
        chk("stall_commit_we", bus.buf_we, 1);
        chk("stall_commit_addr", bus.buf_waddr, 50);
        chk("stall_commit_data", bus.buf_wdata, 8'hAA);
        chk("stall_commit_busy", busy, 1);
        lut_mem[SC_KEY] = 8'h63;
        cyc();
        #1;
        chk("stall_hold_addr", bus.buf_waddr, 50);
        bus.proc_req = 1'b0;
        #1;
        chk("stall_kb_we", bus.buf_we, 1);
        chk("stall_kb_addr", bus.buf_waddr, 10);
        chk("stall_kb_data", bus.buf_wdata, 8'h62);
        chk("stall_kb_gnt", bus.proc_gnt, 0);
        cyc();
        #1;
        chk("stall_cursor", cursor, 11);
        chk("stall_busy", busy, 0);
        chk("stall_vram10", vram[10], 8'h62);
        chk("stall_vram50", vram[50], 8'hAA);

        // Second byte during LOOKUP: dropped, overrun set, first char written.
        lut_mem[SC_KEY] = 8'h41;
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = SC_KEY;
        cyc();
        bus.kb_data = 8'h15;
        cyc();
        bus.kb_valid = 1'b0;
        #1;
        chk("ovr_we", bus.buf_we, 1);
        chk("ovr_addr", bus.buf_waddr, 11);
        chk("ovr_data", bus.buf_wdata, 8'h41);
        chk("ovr_flag", overrun, 1);
        cyc();
        #1;
        chk("ovr_cursor", cursor, 12);
        chk("ovr_lut_addr", bus.lut_addr, SC_KEY);

        // Break sequence produces no write.
        wes = 0;
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'hF0;
        cyc();
        bus.kb_data = SC_KEY;
        cyc();
        bus.kb_valid = 1'b0;
        repeat (4) begin
            #1;
            if (bus.buf_we !== 1'b0) wes++;
            cyc();
        end
        #1;
        chk("break_writes", wes, 0);
        chk("break_cursor", cursor, 12);
        chk("break_busy", busy, 0);

        // Extended prefix is ignored in IDLE.
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'hE0;
        cyc();
        bus.kb_valid = 1'b0;
        #1;
        chk("ext_busy", busy, 0);
        chk("ext_lut_addr", bus.lut_addr, SC_KEY);

        // clr while the keyboard write is stalled in COMMIT.
        cyc();
        bus.kb_valid = 1'b1;
        bus.kb_data  = SC_KEY;
        cyc();
        bus.kb_valid   = 1'b0;
        bus.proc_req   = 1'b1;
        bus.proc_addr  = 7'd5;
        bus.proc_wdata = 8'h11;
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        sweep_check();
        bus.proc_req = 1'b0;
        cyc();
        cyc();
        #1;
        chk("clr_commit_cursor", cursor, 0);
        chk("clr_commit_busy", busy, 0);

        // Randomised traffic against the screen/cursor reference model.
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 9))
                0:       lut_mem[i] = 8'h00;
                1:       lut_mem[i] = 8'h08;
                2:       lut_mem[i] = 8'h0D;
                3:       lut_mem[i] = 8'($urandom_range(127, 255));
                default: lut_mem[i] = 8'($urandom_range(32, 126));
            endcase
        end
        do_clear();
        for (int i = 0; i < 108; i++) scr[i] = 8'h20;
        mcur = 0;
        for (int op = 0; op < 150; op++) begin
            r    = $urandom_range(0, 19);
            code = 8'($urandom_range(0, 255));
            if (code == 8'hF0 || code == 8'hE0) code = SC_KEY;
            a = $urandom_range(0, 107);
            d = 8'($urandom_range(0, 255));
            case (r)
                0: begin
                    do_clear();
                    for (int i = 0; i < 108; i++) scr[i] = 8'h20;
                    mcur = 0;
                end
                1: begin
                    send_key(8'hF0);
                    send_key(code);
                end
                2: begin
                    send_key(8'hE0);
                    send_key(code);
                    model_key(code);
                end
                3, 4, 5: begin
                    proc_write(a, d);
                    scr[a] = d;
                end
                6, 7: begin
                    k = $urandom_range(1, 3);
                    cyc();
                    bus.kb_valid = 1'b1;
                    bus.kb_data  = code;
                    cyc();
                    bus.kb_valid   = 1'b0;
                    bus.proc_req   = 1'b1;
                    bus.proc_addr  = 7'(a);
                    bus.proc_wdata = d;
                    repeat (k) cyc();
                    bus.proc_req = 1'b0;
                    wait_idle(20);
                    scr[a] = d;
                    model_key(code);
                end
                default: begin
                    send_key(code);
                    model_key(code);
                end
            endcase
            chk("rand_cursor", cursor, mcur);
        end
        cyc();
        cyc();
        bad = 0;
        for (int i = 0; i < 108; i++) if (vram[i] !== scr[i]) bad++;
        chk("rand_screen_mismatches", bad, 0);
        chk("rand_overrun", overrun, 0);

        // Asynchronous reset in the middle of the sweep.
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n = 0;
        #1;
        while (bus.buf_waddr !== 7'd50 && n < 200) begin
            cyc();
            #1;
            n++;
        end
        chk("sweep_reach_50", bus.buf_waddr, 50);
        bus.proc_req = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_we", bus.buf_we, 0);
        chk("arst_gnt", bus.proc_gnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cursor", cursor, 0);
        chk("arst_lut_addr", bus.lut_addr, 0);
        cyc();
        bus.proc_req = 1'b0;
        reset        = 1'b1;
        cyc();
        #1;
        chk("arst_after_busy", busy, 0);
        chk("arst_after_we", bus.buf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
